// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one APB master port.
// Transfers run IDLE -> SETUP -> ACCESS, with an ACCESS wait timeout and a rest cycle after each completion.
module apb_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               pclk,
    input  logic               prst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [DW-1:0]      rdata,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [CW-1:0]   wait_cnt;

    logic [NREQ-1:0] eligible_c;
    logic            win_valid_c;
    logic [IW-1:0]   win_idx_c;
    logic            grant_c;
    logic            finish_c;

    assign eligible_c = req & ~done;

    // Round-robin scan starting just after the most recently granted index.
    always_comb begin
        logic [IW-1:0] cand;
        cand        = '0;
        win_valid_c = 1'b0;
        win_idx_c   = last;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IW'((int'(last) + k) % int'(NREQ));
            if (!win_valid_c && eligible_c[cand]) begin
                win_valid_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end

    // The cycle carrying done is a mandatory rest cycle: no new grant while done is high.
    assign grant_c  = (state == IDLE) && win_valid_c && (done == '0);
    assign finish_c = pready || (wait_cnt == CW'(TIMEOUT));

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state    <= IDLE;
            last     <= IW'(NREQ - 1);
            wait_cnt <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        state    <= SETUP;
                        last     <= win_idx_c;
                        wait_cnt <= '0;
                        gnt      <= NREQ'(1) << win_idx_c;
                        paddr    <= req_addr[win_idx_c*AW +: AW];
                        pwdata   <= req_wdata[win_idx_c*DW +: DW];
                        pwrite   <= req_write[win_idx_c];
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // Completion by pready, or abort once the wait budget is spent.
                    if (finish_c) begin
                        state   <= IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        gnt     <= '0;
                        done    <= gnt;
                        err     <= pready ? pslverr : 1'b1;
                        if (pready && !pwrite) begin
                            rdata <= prdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of requesters.
- AW, 4, APB address width.
- DW, 8, APB data width.
- TIMEOUT, 15, maximum ACCESS wait cycles with pready low.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- pclk  in  1  single clock; all logic on rising edge.
- prst  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester transfer request; held until that requester's done.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  requester i address at [i*AW +: AW].
- req_wdata  in  NREQ*DW  requester i write data at [i*DW +: DW].
- gnt  out  NREQ  one-hot owner of the bus, SETUP through completion.
- done  out  NREQ  one-cycle completion pulse to the owner.
- err  out  1  high with done when the transfer ended by pslverr or timeout.
- rdata  out  DW  read data, valid while done is high for a read.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Function
REQ-003 All outputs SHALL be registered.

REQ-004 The FSM SHALL have three states: IDLE, SETUP, ACCESS.

REQ-005 IDLE, winner selection:
- Requester i is eligible when req[i]=1 and done[i]=0.
- If any requester is eligible, the winner SHALL be the first eligible index scanning last+1, last+2, ... modulo NREQ.
- "last" is the most recently granted index.

REQ-006 IDLE, latch and move:
- On that same edge the block SHALL latch the winner's addr, wdata and write onto paddr/pwdata/pwrite.
- It SHALL set gnt to the winner's one-hot value, set psel=1, penable=0, and go to SETUP.
- It SHALL update last to the winner.

REQ-007 SETUP SHALL last exactly one cycle, then go to ACCESS with penable=1 and psel=1.

REQ-008 ACCESS with pready=0:
- Stay in ACCESS.
- Increment the wait counter (width clog2(TIMEOUT+1)), which is cleared on entry to SETUP.

REQ-009 ACCESS with pready=1 (completion edge):
- Go to IDLE and clear psel, penable and gnt.
- Pulse done[owner] for one cycle.
- Set err=pslverr.
- Load rdata=prdata if the transfer is a read; hold the previous rdata if it is a write.

REQ-010 ACCESS timeout:
- If pready=0 and the wait counter equals TIMEOUT, abort to IDLE exactly as in REQ-009, with err=1 and rdata unchanged.
- Total ACCESS cycles on a timeout SHALL equal TIMEOUT+1.

REQ-011 Minimum occupancy:
- Every transfer SHALL occupy at least one IDLE cycle between completion and the next SETUP.
- Minimum transfer time is 3 cycles from request sampled to done.

REQ-012 paddr, pwdata and pwrite SHALL remain stable from SETUP until completion; req_* changes during a transfer SHALL be ignored.

REQ-013 A requester that deasserts req before its grant SHALL simply be skipped; a deassertion after grant SHALL NOT abort the transfer.

REQ-014 done and err SHALL be zero in every cycle other than the post-completion IDLE cycle.

REQ-015 With a single persistent requester, the grant SHALL repeat every 4 cycles.

Reset
REQ-016 prst=0 SHALL immediately, without waiting for a clock edge, set:
- state = IDLE
- psel = penable = pwrite = 0
- paddr = pwdata = rdata = 0
- gnt = done = err = 0
- wait counter = 0
- last = NREQ-1

REQ-017 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.

REQ-018 After prst rises, the first grant SHALL go to the lowest eligible index.

Verification
REQ-019 Single write: req[0]=1, write=1, addr=4'h3, wdata=8'hA5, pready=1 -> psel high for 2 cycles, penable in the second; paddr=3, pwdata=A5; done[0] one cycle later; err=0.

REQ-020 Read with waits: req[2] read, addr=4'h9, pready low for 3 ACCESS cycles then high with prdata=8'h5C -> penable high for 4 cycles; rdata=5C with done[2]=1.

REQ-021 Round robin: req=4'b1111 held, each dropped on its done -> grant order 0,1,2,3 with 4-cycle spacing, each requester granted exactly once.

REQ-022 Fairness after grant: req[1] and req[3] held, last=1 -> next grant goes to 3, then to 1.

REQ-023 Timeout and error:
- pready held low -> abort after 16 ACCESS cycles with done=1, err=1.
- Separately, pready=1 with pslverr=1 -> err=1.

REQ-024 Reset mid-ACCESS: prst=0 while penable=1 -> psel=penable=gnt=0 immediately and no done; after release, req[3] alone -> granted normally.
